// File: rtl/serial_tx.sv
// Serial frame transmitter: start, DATA_WIDTH bits LSB first, optional parity, stop; tx goes low on the accept edge.
// One word per (2+DATA_WIDTH+PARITY_EN)*CLKS_PER_BIT+1 cycles; tx_ready stays low for the whole frame, with no queueing.
module serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  busy
);

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  rdy_q, rdy_d;
    logic                  bit_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        bit_end = (div_q == DIV_LAST);

        if (state_q != S_IDLE) begin
            div_d = bit_end ? '0 : div_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tx_valid && rdy_q) begin
                    state_d = S_START;
                    div_d   = '0;
                    shift_d = tx_data;
                    par_d   = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Line level is registered from the next state so tx changes on the same edge as the state.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        rdy_d = (state_d == S_IDLE);
    end

    assign tx       = tx_q;
    assign tx_ready = rdy_q;
    assign busy     = ~rdy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: four instances cover no parity, even parity, odd parity and one clock per bit.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic [3:0] vld;
    logic [3:0] tx_w, rdy_w, busy_w;
    int         checks = 0;
    int         failures = 0;
    logic [127:0] cap_tx, cap_rdy, cap_bsy;

    always #5 clk = ~clk;

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst(rst), .tx_data(din), .tx_valid(vld[0]),
        .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .tx_data(din), .tx_valid(vld[1]),
        .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .rst(rst), .tx_data(din), .tx_valid(vld[2]),
        .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));
    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u3 (
        .clk(clk), .rst(rst), .tx_data(din), .tx_valid(vld[3]),
        .tx_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

    // Present one word to instance s for exactly one rising edge (the accept edge A).
    task automatic send(input int s, input logic [7:0] d);
        @(negedge clk);
        din    = d;
        vld[s] = 1'b1;
        @(posedge clk);
        #1;
        vld[s] = 1'b0;
    endtask

    // Sample i holds the outputs between edges A+i and A+i+1.
    task automatic capture(input int s, input int n, output logic [127:0] t,
                           output logic [127:0] r, output logic [127:0] b);
        t = '0; r = '0; b = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            t[i] = tx_w[s];
            r[i] = rdy_w[s];
            b[i] = busy_w[s];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vld = '0;
        din = '0;
        #12;
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (tx_w[s] !== 1'b1 || rdy_w[s] !== 1'b1 || busy_w[s] !== 1'b0) begin
                failures++;
                $display("FAIL reset inst%0d got tx=%b rdy=%b busy=%b exp 1 1 0",
                         s, tx_w[s], rdy_w[s], busy_w[s]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] lv;
        lv = {6'd0, 1'b1, 8'hA5, 1'b0};
        send(0, 8'hA5);
        capture(0, 41, cap_tx, cap_rdy, cap_bsy);
        for (int i = 0; i < 41; i++) begin
            logic et, er;
            et = (i < 40) ? lv[i/4] : 1'b1;
            er = (i >= 40);
            checks++;
            if (cap_tx[i] !== et || cap_rdy[i] !== er || cap_bsy[i] !== ~er) begin
                failures++;
                $display("FAIL basic cyc%0d got tx=%b rdy=%b busy=%b exp tx=%b rdy=%b busy=%b",
                         i, cap_tx[i], cap_rdy[i], cap_bsy[i], et, er, ~er);
            end
        end
    endtask

    task automatic test_parity();
        logic [7:0]  words [2];
        logic        even_par [2];
        logic        p;
        logic [15:0] lv;
        words[0] = 8'hA5; even_par[0] = 1'b0;
        words[1] = 8'h07; even_par[1] = 1'b1;
        for (int s = 1; s <= 2; s++) begin
            for (int j = 0; j < 2; j++) begin
                p  = (s == 1) ? even_par[j] : ~even_par[j];
                lv = {5'd0, 1'b1, p, words[j], 1'b0};
                send(s, words[j]);
                capture(s, 45, cap_tx, cap_rdy, cap_bsy);
                for (int i = 0; i < 45; i++) begin
                    logic et, er;
                    et = (i < 44) ? lv[i/4] : 1'b1;
                    er = (i >= 44);
                    checks++;
                    if (cap_tx[i] !== et || cap_rdy[i] !== er) begin
                        failures++;
                        $display("FAIL parity inst%0d word%0d cyc%0d got tx=%b rdy=%b exp tx=%b rdy=%b",
                                 s, j, i, cap_tx[i], cap_rdy[i], et, er);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] lv1, lv2;
        lv1 = {6'd0, 1'b1, 8'h3C, 1'b0};
        lv2 = {6'd0, 1'b1, 8'hC3, 1'b0};
        @(negedge clk);
        din    = 8'h3C;
        vld[0] = 1'b1;
        @(posedge clk);
        #1;
        din = 8'hC3;
        capture(0, 82, cap_tx, cap_rdy, cap_bsy);
        vld[0] = 1'b0;
        for (int i = 0; i < 82; i++) begin
            logic et, er;
            if (i < 40)      et = lv1[i/4];
            else if (i < 41) et = 1'b1;
            else if (i < 81) et = lv2[(i-41)/4];
            else             et = 1'b1;
            er = (i == 40) || (i == 81);
            checks++;
            if (cap_tx[i] !== et || cap_rdy[i] !== er) begin
                failures++;
                $display("FAIL b2b cyc%0d got tx=%b rdy=%b exp tx=%b rdy=%b",
                         i, cap_tx[i], cap_rdy[i], et, er);
            end
        end
    endtask

    task automatic test_ignored();
        logic [15:0] lv;
        lv = {6'd0, 1'b1, 8'h5A, 1'b0};
        send(0, 8'h5A);
        fork
            capture(0, 50, cap_tx, cap_rdy, cap_bsy);
            begin
                repeat (10) @(negedge clk);
                din    = 8'hFF;
                vld[0] = 1'b1;
                @(negedge clk);
                vld[0] = 1'b0;
                repeat (5) @(negedge clk);
                din = 8'h00;
            end
        join
        for (int i = 0; i < 50; i++) begin
            logic et, er;
            et = (i < 40) ? lv[i/4] : 1'b1;
            er = (i >= 40);
            checks++;
            if (cap_tx[i] !== et || cap_rdy[i] !== er) begin
                failures++;
                $display("FAIL ignored cyc%0d got tx=%b rdy=%b exp tx=%b rdy=%b",
                         i, cap_tx[i], cap_rdy[i], et, er);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] lv;
        lv = {6'd0, 1'b1, 8'h81, 1'b0};
        send(0, 8'h00);
        repeat (18) @(negedge clk);
        checks++;
        if (tx_w[0] !== 1'b0 || rdy_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_bit3 got tx=%b rdy=%b exp tx=0 rdy=0", tx_w[0], rdy_w[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (tx_w[0] !== 1'b1 || rdy_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async got tx=%b rdy=%b busy=%b exp 1 1 0",
                     tx_w[0], rdy_w[0], busy_w[0]);
        end
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        din    = 8'h81;
        vld[0] = 1'b1;
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        capture(0, 41, cap_tx, cap_rdy, cap_bsy);
        for (int i = 0; i < 41; i++) begin
            logic et, er;
            et = (i < 40) ? lv[i/4] : 1'b1;
            er = (i >= 40);
            checks++;
            if (cap_tx[i] !== et || cap_rdy[i] !== er) begin
                failures++;
                $display("FAIL rstmid_frame cyc%0d got tx=%b rdy=%b exp tx=%b rdy=%b",
                         i, cap_tx[i], cap_rdy[i], et, er);
            end
        end
    endtask

    task automatic test_cpb1();
        logic [15:0] lv;
        lv = {6'd0, 1'b1, 8'h55, 1'b0};
        send(3, 8'h55);
        capture(3, 11, cap_tx, cap_rdy, cap_bsy);
        for (int i = 0; i < 11; i++) begin
            logic et, er;
            et = (i < 10) ? lv[i] : 1'b1;
            er = (i >= 10);
            checks++;
            if (cap_tx[i] !== et || cap_rdy[i] !== er) begin
                failures++;
                $display("FAIL cpb1 cyc%0d got tx=%b rdy=%b exp tx=%b rdy=%b",
                         i, cap_tx[i], cap_rdy[i], et, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
        test_cpb1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
